mux32_rr_sched: RTL and testbench

Round-robin scheduler that shares the 32:1 select tree (MUX32) between 32 requesting channels. It picks one requesting channel and drives the 5-bit select. It holds that select stable until the owner releases, drops its request, or exceeds a hold limit, then rotates fairly to the next requester. It sits between the channel request lines and the MUX32 select input. Its grant outputs tell the downstream sampler which channel is currently on the mux output.

---
 rtl/mux32_rr_sched_pkg.sv | 10 +
 rtl/mux32_rr_sched_pick.sv | 25 ++
 rtl/mux32_rr_sched.sv | 95 +++++++++
 tb/tb_mux32_rr_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux32_rr_sched_pkg.sv
// Shared definitions for the MUX32 round-robin scheduler.
package mux32_rr_sched_pkg;
    localparam int N_CH  = 32;
    localparam int SEL_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/mux32_rr_sched_pick.sv
// Rotating-priority finder: first set request strictly after last_ptr, wrapping.
import mux32_rr_sched_pkg::*;

module rr_pick32 (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit after last_ptr wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = last_ptr + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux32_rr_sched.sv
// Round-robin owner of the MUX32 select; holds a grant until release or hold limit.
import mux32_rr_sched_pkg::*;

module mux32_rr_sched #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_CH-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  grant,
    output logic             grant_valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [N_CH-1:0]  ONE       = N_CH'(1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0] last_ptr, last_d, sel_d;
    logic [N_CH-1:0]  grant_d;
    logic             gv_d, timeout_d;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             hold_hit, owner_drop, release_now;

    rr_pick32 u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .idx      (win_idx),
        .found    (win_found)
    );

    assign hold_hit    = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign owner_drop  = !req[sel];
    assign release_now = done || owner_drop || hold_hit;

    // Next-state and next-output decode; timeout only flags a pure hold-limit release.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        last_d    = last_ptr;
        sel_d     = sel;
        grant_d   = grant;
        gv_d      = grant_valid;
        timeout_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && win_found) begin
                    state_d = ST_GRANT;
                    sel_d   = win_idx;
                    grant_d = ONE << win_idx;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    gv_d      = 1'b0;
                    last_d    = sel;
                    timeout_d = hold_hit && !done && !owner_drop;
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset lands the search start at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_ptr    <= SEL_W'(N_CH - 1);
            sel         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_ptr    <= last_d;
            sel         <= sel_d;
            grant       <= grant_d;
            grant_valid <= gv_d;
            timeout     <= timeout_d;
        end
    end
endmodule

// File: tb/tb_mux32_rr_sched.sv
// Directed bench for mux32_rr_sched with a 4-cycle hold limit.
module tb_mux32_rr_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] req = '0;
    logic        done = 1'b0;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        grant_valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    mux32_rr_sched #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (sel !== 5'd0 || grant !== 32'h0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: sel=%0d grant=%h gv=%b to=%b want 0/0/0/0", sel, grant, grant_valid, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 32'h1; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd0 || grant !== 32'h1) begin
            errors++;
            $display("FAIL single_grant: gv=%b sel=%0d grant=%h want 1/0/00000001", grant_valid, sel, grant);
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: gv=%b want 1", grant_valid);
        end
        done = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant !== 32'h0 || timeout !== 1'b0 || sel !== 5'd0) begin
            errors++;
            $display("FAIL single_release: gv=%b grant=%h to=%b sel=%0d want 0/0/0/0", grant_valid, grant, timeout, sel);
        end
        done = 1'b0; req = '0;
    endtask

    task automatic test_rotate();
        logic [4:0] exp_order [6];
        exp_order = '{5'd0, 5'd4, 5'd31, 5'd0, 5'd4, 5'd31};
        pulse_reset();
        req = 32'h8000_0011; enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || sel !== exp_order[k] || grant !== (32'h1 << exp_order[k])) begin
                errors++;
                $display("FAIL rotate_%0d: gv=%b sel=%0d grant=%h want sel=%0d", k, grant_valid, sel, grant, exp_order[k]);
            end
            @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotate_gap_%0d: gv=%b want 0", k, grant_valid);
            end
            done = 1'b0;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        pulse_reset();
        req = 32'h80; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || sel !== 5'd7 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: gv=%b sel=%0d to=%b want 1/7/0", k, grant_valid, sel, timeout);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: gv=%b to=%b want 0/1", grant_valid, timeout);
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd7 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL regrant_7: gv=%b sel=%0d to=%b want 1/7/0", grant_valid, sel, timeout);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_timeout: gv=%b to=%b want 0/0", grant_valid, timeout);
        end
    endtask

    task automatic test_drop();
        pulse_reset();
        req = 32'h204; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd2) begin
            errors++;
            $display("FAIL drop_first: gv=%b sel=%0d want 1/2", grant_valid, sel);
        end
        req = 32'h200;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: gv=%b to=%b want 0/0", grant_valid, timeout);
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd9 || grant !== 32'h200) begin
            errors++;
            $display("FAIL drop_next9: gv=%b sel=%0d grant=%h want 1/9/00000200", grant_valid, sel, grant);
        end
        done = 1'b1; req = '0;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0 || sel !== 5'd9) begin
            errors++;
            $display("FAIL done_and_drop: gv=%b to=%b sel=%0d want 0/0/9", grant_valid, timeout, sel);
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release_only: gv=%b to=%b want 0/0", grant_valid, timeout);
        end
        done = 1'b0;
    endtask

    task automatic test_enable();
        pulse_reset();
        req = 32'h8; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd3) begin
            errors++;
            $display("FAIL en_grant3: gv=%b sel=%0d want 1/3", grant_valid, sel);
        end
        enable = 1'b0; req = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd3) begin
            errors++;
            $display("FAIL en_continue: gv=%b sel=%0d want 1/3", grant_valid, sel);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant !== 32'h0 || sel !== 5'd3) begin
            errors++;
            $display("FAIL en_blocked: gv=%b grant=%h sel=%0d want 0/0/3", grant_valid, grant, sel);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd4 || grant !== 32'h10) begin
            errors++;
            $display("FAIL en_next4: gv=%b sel=%0d grant=%h want 1/4/00000010", grant_valid, sel, grant);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant !== 32'h0 || sel !== 5'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gv=%b grant=%h sel=%0d to=%b want 0/0/0/0", grant_valid, grant, sel, timeout);
        end
        rst = 1'b0;
        req = 32'hFFFF_FFFF; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd0 || grant !== 32'h1) begin
            errors++;
            $display("FAIL post_reset_ch0: gv=%b sel=%0d grant=%h want 1/0/00000001", grant_valid, sel, grant);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || sel !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_ch1: gv=%b sel=%0d want 1/1", grant_valid, sel);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_timeout();
        test_drop();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
